// File: rtl/core_bus_arbiter_if.sv
// Bus bundle between the core's ibus/dbus ports, the arbiter, and the memory-side request channel.
// The slave modport is the arbiter's view; the master modport is the core plus memory side.
interface core_bus_arbiter_if #(
   parameter int ADDR_W = 64,
   parameter int DATA_W = 64
);
   logic              ireq_valid;
   logic [ADDR_W-1:0] ireq_addr;
   logic              iresp_addr_ok;
   logic              iresp_data_ok;
   logic [31:0]       iresp_data;

   logic              dreq_valid;
   logic [ADDR_W-1:0] dreq_addr;
   logic [2:0]        dreq_size;
   logic [7:0]        dreq_strobe;
   logic [DATA_W-1:0] dreq_data;
   logic              dresp_addr_ok;
   logic              dresp_data_ok;
   logic [DATA_W-1:0] dresp_data;

   logic              mreq_valid;
   logic              mreq_write;
   logic [ADDR_W-1:0] mreq_addr;
   logic [2:0]        mreq_size;
   logic [7:0]        mreq_strobe;
   logic [DATA_W-1:0] mreq_data;
   logic              mresp_ok;
   logic [DATA_W-1:0] mresp_data;

   modport slave (
      input  ireq_valid, ireq_addr,
      output iresp_addr_ok, iresp_data_ok, iresp_data,
      input  dreq_valid, dreq_addr, dreq_size, dreq_strobe, dreq_data,
      output dresp_addr_ok, dresp_data_ok, dresp_data,
      output mreq_valid, mreq_write, mreq_addr, mreq_size, mreq_strobe, mreq_data,
      input  mresp_ok, mresp_data
   );

   modport master (
      output ireq_valid, ireq_addr,
      input  iresp_addr_ok, iresp_data_ok, iresp_data,
      output dreq_valid, dreq_addr, dreq_size, dreq_strobe, dreq_data,
      input  dresp_addr_ok, dresp_data_ok, dresp_data,
      input  mreq_valid, mreq_write, mreq_addr, mreq_size, mreq_strobe, mreq_data,
      output mresp_ok, mresp_data
   );
endinterface

// File: rtl/core_bus_arbiter.sv
// Serialises ibus/dbus requests onto a single-outstanding memory channel.
// Define CORE_BUS_ARBITER_RR_EN for round-robin on contention instead of fixed dbus priority.
module core_bus_arbiter #(
   parameter int ADDR_W = 64,
   parameter int DATA_W = 64
) (
   input logic               clk,
   input logic               reset,
   core_bus_arbiter_if.slave bus
);
   localparam logic [2:0] MSIZE4 = 3'b010;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      BUSY_I = 2'd1,
      BUSY_D = 2'd2
   } state_t;

   state_t            state_q, state_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic [2:0]        size_q, size_d;
   logic [7:0]        strobe_q, strobe_d;
   logic [DATA_W-1:0] data_q, data_d;
   logic              pick_dbus;
   logic              grant_i, grant_d;

`ifdef CORE_BUS_ARBITER_RR_EN
   logic              last_grant_q, last_grant_d;

   // On contention, hand the grant to whichever client did not get the previous one.
   assign pick_dbus = bus.dreq_valid && (!bus.ireq_valid || !last_grant_q);
`else
   assign pick_dbus = bus.dreq_valid;
`endif

   always_comb begin
      state_d  = state_q;
      addr_d   = addr_q;
      size_d   = size_q;
      strobe_d = strobe_q;
      data_d   = data_q;
      grant_i  = 1'b0;
      grant_d  = 1'b0;
      case (state_q)
         IDLE: begin
            if (pick_dbus) begin
               grant_d  = 1'b1;
               state_d  = BUSY_D;
               addr_d   = bus.dreq_addr;
               size_d   = bus.dreq_size;
               strobe_d = bus.dreq_strobe;
               data_d   = bus.dreq_data;
            end else if (bus.ireq_valid) begin
               grant_i  = 1'b1;
               state_d  = BUSY_I;
               addr_d   = bus.ireq_addr;
               size_d   = MSIZE4;
               strobe_d = '0;
               data_d   = '0;
            end
         end
         BUSY_I, BUSY_D: begin
            if (bus.mresp_ok) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

`ifdef CORE_BUS_ARBITER_RR_EN
   always_comb begin
      last_grant_d = last_grant_q;
      if (grant_d)      last_grant_d = 1'b1;
      else if (grant_i) last_grant_d = 1'b0;
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) last_grant_q <= 1'b0;
      else       last_grant_q <= last_grant_d;
   end
`endif

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q  <= IDLE;
         addr_q   <= '0;
         size_q   <= '0;
         strobe_q <= '0;
         data_q   <= '0;
      end else begin
         state_q  <= state_d;
         addr_q   <= addr_d;
         size_q   <= size_d;
         strobe_q <= strobe_d;
         data_q   <= data_d;
      end
   end

   // Memory side sees only registered state, so client inputs never reach it combinationally.
   assign bus.mreq_valid  = (state_q != IDLE);
   assign bus.mreq_write  = |strobe_q;
   assign bus.mreq_addr   = addr_q;
   assign bus.mreq_size   = size_q;
   assign bus.mreq_strobe = strobe_q;
   assign bus.mreq_data   = data_q;

   always_comb begin
      bus.iresp_addr_ok = 1'b0;
      bus.iresp_data_ok = 1'b0;
      bus.iresp_data    = '0;
      bus.dresp_addr_ok = 1'b0;
      bus.dresp_data_ok = 1'b0;
      bus.dresp_data    = '0;
      if (bus.mresp_ok && state_q == BUSY_I) begin
         bus.iresp_addr_ok = 1'b1;
         bus.iresp_data_ok = 1'b1;
         bus.iresp_data    = addr_q[2] ? bus.mresp_data[63:32] : bus.mresp_data[31:0];
      end
      if (bus.mresp_ok && state_q == BUSY_D) begin
         bus.dresp_addr_ok = 1'b1;
         bus.dresp_data_ok = 1'b1;
         bus.dresp_data    = bus.mresp_data;
      end
   end
endmodule

// File: tb/tb_core_bus_arbiter.sv
// Directed self-checking bench for core_bus_arbiter: inputs change on the falling edge,
// outputs are checked 1 time unit later, state advances on the rising edge.
module tb_core_bus_arbiter;
   logic clk;
   logic reset;
   int   checks;
   int   errors;

   core_bus_arbiter_if #(.ADDR_W(64), .DATA_W(64)) bus ();

   core_bus_arbiter #(.ADDR_W(64), .DATA_W(64)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic check_output(input string tag, input logic [63:0] observed, input logic [63:0] expected);
      checks++;
      assert (observed === expected)
      else begin
         errors++;
         $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
      end
   endtask

   task automatic next_cycle();
      @(negedge clk);
   endtask

   task automatic check_client_quiet(input string tag);
      check_output({tag, ".iresp_data_ok"}, 64'(bus.iresp_data_ok), 64'd0);
      check_output({tag, ".iresp_addr_ok"}, 64'(bus.iresp_addr_ok), 64'd0);
      check_output({tag, ".iresp_data"},    64'(bus.iresp_data),    64'd0);
      check_output({tag, ".dresp_data_ok"}, 64'(bus.dresp_data_ok), 64'd0);
      check_output({tag, ".dresp_addr_ok"}, 64'(bus.dresp_addr_ok), 64'd0);
      check_output({tag, ".dresp_data"},    bus.dresp_data,         64'd0);
   endtask

   initial begin
      logic        rr_build;
      logic [63:0] first_addr;
      logic [63:0] second_addr;
      checks = 0;
      errors = 0;
`ifdef CORE_BUS_ARBITER_RR_EN
      rr_build = 1'b1;
`else
      rr_build = 1'b0;
`endif
      reset           = 1'b1;
      bus.ireq_valid  = 1'b0;
      bus.ireq_addr   = '0;
      bus.dreq_valid  = 1'b0;
      bus.dreq_addr   = '0;
      bus.dreq_size   = '0;
      bus.dreq_strobe = '0;
      bus.dreq_data   = '0;
      bus.mresp_ok    = 1'b0;
      bus.mresp_data  = '0;

      // Reset state
      #2;
      check_output("rst.mreq_valid", 64'(bus.mreq_valid), 64'd0);
      check_output("rst.mreq_addr",  bus.mreq_addr,        64'd0);
      check_output("rst.mreq_write", 64'(bus.mreq_write), 64'd0);
      check_client_quiet("rst");
      next_cycle();
      reset = 1'b0;

      // ibus-only fetch from an upper-word address
      next_cycle();
      bus.ireq_valid = 1'b1;
      bus.ireq_addr  = 64'h8000_0004;
      #1 check_output("ibus.idle_no_mreq", 64'(bus.mreq_valid), 64'd0);
      next_cycle();
      #1;
      check_output("ibus.mreq_valid", 64'(bus.mreq_valid),  64'd1);
      check_output("ibus.mreq_addr",  bus.mreq_addr,         64'h8000_0004);
      check_output("ibus.mreq_size",  64'(bus.mreq_size),   64'd2);
      check_output("ibus.mreq_write", 64'(bus.mreq_write),  64'd0);
      check_output("ibus.mreq_strobe", 64'(bus.mreq_strobe), 64'd0);
      check_output("ibus.no_early_ok", 64'(bus.iresp_data_ok), 64'd0);
      next_cycle();
      bus.mresp_ok   = 1'b1;
      bus.mresp_data = 64'h1111_2222_3333_4444;
      #1;
      check_output("ibus.data_ok", 64'(bus.iresp_data_ok), 64'd1);
      check_output("ibus.addr_ok", 64'(bus.iresp_addr_ok), 64'd1);
      check_output("ibus.data",    64'(bus.iresp_data),    64'h1111_2222);
      check_output("ibus.dbus_quiet", 64'(bus.dresp_data_ok), 64'd0);
      next_cycle();
      bus.mresp_ok   = 1'b0;
      bus.ireq_valid = 1'b0;
      #1;
      check_output("ibus.back_idle", 64'(bus.mreq_valid), 64'd0);
      check_output("ibus.single_pulse", 64'(bus.iresp_data_ok), 64'd0);

      // dbus write held through a stall
      next_cycle();
      bus.dreq_valid  = 1'b1;
      bus.dreq_addr   = 64'h8000_1000;
      bus.dreq_size   = 3'b011;
      bus.dreq_strobe = 8'h0F;
      bus.dreq_data   = 64'hDEAD_BEEF;
      for (int i = 0; i < 3; i++) begin
         next_cycle();
         #1;
         check_output("dwr.mreq_valid",  64'(bus.mreq_valid),  64'd1);
         check_output("dwr.mreq_write",  64'(bus.mreq_write),  64'd1);
         check_output("dwr.mreq_strobe", 64'(bus.mreq_strobe), 64'h0F);
         check_output("dwr.mreq_data",   bus.mreq_data,         64'hDEAD_BEEF);
         check_output("dwr.mreq_addr",   bus.mreq_addr,         64'h8000_1000);
         check_output("dwr.mreq_size",   64'(bus.mreq_size),   64'd3);
      end
      next_cycle();
      bus.mresp_ok   = 1'b1;
      bus.mresp_data = 64'h5555_6666_7777_8888;
      #1;
      check_output("dwr.data_ok", 64'(bus.dresp_data_ok), 64'd1);
      check_output("dwr.addr_ok", 64'(bus.dresp_addr_ok), 64'd1);
      check_output("dwr.data",    bus.dresp_data,         64'h5555_6666_7777_8888);
      check_output("dwr.ibus_ok", 64'(bus.iresp_data_ok), 64'd0);
      check_output("dwr.ibus_data", 64'(bus.iresp_data), 64'd0);
      next_cycle();
      bus.mresp_ok   = 1'b0;
      bus.dreq_valid = 1'b0;
      #1;
      check_output("dwr.single_pulse", 64'(bus.dresp_data_ok), 64'd0);
      check_output("dwr.back_idle",    64'(bus.mreq_valid),    64'd0);

      // Stray response while idle
      next_cycle();
      bus.mresp_ok   = 1'b1;
      bus.mresp_data = 64'hFFFF_EEEE_DDDD_CCCC;
      #1;
      check_client_quiet("stray");
      next_cycle();
      bus.mresp_ok = 1'b0;
      #1 check_output("stray.stay_idle", 64'(bus.mreq_valid), 64'd0);

      // Contention right after a dbus grant
      next_cycle();
      bus.ireq_valid  = 1'b1;
      bus.ireq_addr   = 64'h8000_0000;
      bus.dreq_valid  = 1'b1;
      bus.dreq_addr   = 64'h8000_2000;
      bus.dreq_size   = 3'b011;
      bus.dreq_strobe = 8'h00;
      bus.dreq_data   = 64'h0;
      first_addr  = rr_build ? 64'h8000_0000 : 64'h8000_2000;
      second_addr = rr_build ? 64'h8000_2000 : 64'h8000_0000;
      next_cycle();
      #1;
      check_output("cont.first_addr",  bus.mreq_addr,        first_addr);
      check_output("cont.first_write", 64'(bus.mreq_write), 64'd0);
      next_cycle();
      bus.mresp_ok   = 1'b1;
      bus.mresp_data = 64'hAAAA_BBBB_CCCC_DDDD;
      #1;
      check_output("cont.first_d_ok", 64'(bus.dresp_data_ok), rr_build ? 64'd0 : 64'd1);
      check_output("cont.first_i_ok", 64'(bus.iresp_data_ok), rr_build ? 64'd1 : 64'd0);
      check_output("cont.first_d_data", bus.dresp_data, rr_build ? 64'd0 : 64'hAAAA_BBBB_CCCC_DDDD);
      check_output("cont.first_i_data", 64'(bus.iresp_data), rr_build ? 64'hCCCC_DDDD : 64'd0);
      next_cycle();
      bus.mresp_ok = 1'b0;
      if (rr_build) bus.ireq_valid = 1'b0;
      else          bus.dreq_valid = 1'b0;
      #1 check_output("cont.gap_idle", 64'(bus.mreq_valid), 64'd0);
      next_cycle();
      #1;
      check_output("cont.second_valid", 64'(bus.mreq_valid), 64'd1);
      check_output("cont.second_addr",  bus.mreq_addr,        second_addr);
      bus.mresp_ok   = 1'b1;
      bus.mresp_data = 64'h0123_4567_89AB_CDEF;
      #1;
      check_output("cont.second_i_ok", 64'(bus.iresp_data_ok), rr_build ? 64'd0 : 64'd1);
      check_output("cont.second_d_ok", 64'(bus.dresp_data_ok), rr_build ? 64'd1 : 64'd0);
      next_cycle();
      bus.mresp_ok   = 1'b0;
      bus.ireq_valid = 1'b0;
      bus.dreq_valid = 1'b0;

      // Address stability while the client keeps changing dreq_addr
      next_cycle();
      bus.dreq_valid = 1'b1;
      bus.dreq_addr  = 64'h8000_3000;
      bus.dreq_strobe = 8'h00;
      for (int i = 1; i <= 10; i++) begin
         next_cycle();
         bus.dreq_addr = 64'h8000_3000 + 64'(i * 8);
         #1 check_output("stab.mreq_addr", bus.mreq_addr, 64'h8000_3000);
      end
      next_cycle();
      bus.mresp_ok   = 1'b1;
      bus.mresp_data = 64'h0BAD_F00D_0000_0001;
      #1 check_output("stab.d_data", bus.dresp_data, 64'h0BAD_F00D_0000_0001);
      next_cycle();
      bus.mresp_ok   = 1'b0;
      bus.dreq_valid = 1'b0;

      // ibus valid dropped mid-transaction, lower-word address
      next_cycle();
      bus.ireq_valid = 1'b1;
      bus.ireq_addr  = 64'h8000_0008;
      next_cycle();
      bus.ireq_valid = 1'b0;
      #1 check_output("drop.mreq_valid", 64'(bus.mreq_valid), 64'd1);
      next_cycle();
      bus.mresp_ok   = 1'b1;
      bus.mresp_data = 64'h9999_8888_7777_6666;
      #1;
      check_output("drop.i_ok",   64'(bus.iresp_data_ok), 64'd1);
      check_output("drop.i_data", 64'(bus.iresp_data),    64'h7777_6666);
      next_cycle();
      bus.mresp_ok = 1'b0;

      // Reset in the middle of a dbus transaction
      next_cycle();
      bus.dreq_valid  = 1'b1;
      bus.dreq_addr   = 64'h8000_4000;
      bus.dreq_strobe = 8'hFF;
      bus.dreq_data   = 64'h1234;
      next_cycle();
      #1 check_output("rmid.busy", 64'(bus.mreq_valid), 64'd1);
      #1 reset = 1'b1;
      #1;
      check_output("rmid.async_drop", 64'(bus.mreq_valid), 64'd0);
      check_output("rmid.strobe_clr", 64'(bus.mreq_strobe), 64'd0);
      bus.dreq_valid = 1'b0;
      next_cycle();
      reset          = 1'b0;
      bus.mresp_ok   = 1'b1;
      bus.mresp_data = 64'h4444;
      #1;
      check_output("rmid.late_resp_d", 64'(bus.dresp_data_ok), 64'd0);
      check_output("rmid.late_resp_v", 64'(bus.mreq_valid),    64'd0);
      next_cycle();
      bus.mresp_ok   = 1'b0;
      bus.ireq_valid = 1'b1;
      bus.ireq_addr  = 64'h8000_0104;
      next_cycle();
      #1;
      check_output("rmid.next_valid", 64'(bus.mreq_valid), 64'd1);
      check_output("rmid.next_addr",  bus.mreq_addr,        64'h8000_0104);
      bus.mresp_ok   = 1'b1;
      bus.mresp_data = 64'hCAFE_0001_BEEF_0002;
      #1;
      check_output("rmid.next_ok",   64'(bus.iresp_data_ok), 64'd1);
      check_output("rmid.next_data", 64'(bus.iresp_data),    64'hCAFE_0001);
      next_cycle();
      bus.mresp_ok   = 1'b0;
      bus.ireq_valid = 1'b0;
      next_cycle();

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
